frame_fifo: RTL and testbench

Single-clock, frame-aware receive buffer between the MAC receive byte stream and the transmit controller. It is the parametrised successor to the byte FIFO plus separate frame-length FIFO pair, and merges both into one block. Frames with errors or that overflow are discarded whole. A frame is committed only after its last byte, and its length is presented before its first byte is read. The block also drives a hysteretic pause request toward the flow-control logic.

---
 rtl/eth_fifo_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/frame_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_frame_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_fifo_pkg.sv
// Shared definitions for the frame-aware receive buffer and its length queue.
package eth_fifo_pkg;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Default pause thresholds as fractions of the data buffer depth.
  localparam int PAUSE_HI_NUM = 3;
  localparam int PAUSE_HI_DEN = 4;
  localparam int PAUSE_LO_NUM = 1;
  localparam int PAUSE_LO_DEN = 4;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_FILL    = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_NEXT   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with show-ahead output; holds committed frame lengths.
module sync_fifo
  import eth_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_idx;
  logic [AW:0]      rd_idx;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_idx - rd_idx;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_idx[AW-1:0]];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx[AW-1:0]] <= din;
  end

  // Index registers; one-bit-wider so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + PTR_ONE;
      if (do_pop)  rd_idx <= rd_idx + PTR_ONE;
    end
  end

endmodule

// File: rtl/frame_fifo.sv
// Frame-aware receive buffer: stores whole frames, drops bad or oversized ones,
// presents the head frame length before its data, and raises a hysteretic pause.
//
// state      | meaning
// WR_IDLE    | between frames; the next valid word opens a frame
// WR_FILL    | storing words of an accepted frame
// WR_DISCARD | frame already dropped; ignoring words up to its last
// RD_IDLE    | no committed frame loaded; waiting on the length queue
// RD_STREAM  | head frame loaded; fetching words into the output register
// RD_NEXT    | last word just taken; load and fetch the next head together
module frame_fifo
  import eth_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2048,
  parameter int LEN_DEPTH = 16,
  parameter int LEN_W     = 16,
  parameter int PAUSE_HI  = DEPTH * PAUSE_HI_NUM / PAUSE_HI_DEN,
  parameter int PAUSE_LO  = DEPTH * PAUSE_LO_NUM / PAUSE_LO_DEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_last,
  input  logic                      wr_err,
  output logic                      rd_len_valid,
  output logic [LEN_W-1:0]          rd_len,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  input  logic                      rd_ready,
  output logic [clog2(DEPTH):0]     level,
  output logic [clog2(LEN_DEPTH):0] frames,
  output logic                      pause_req,
  output logic [15:0]               drop_cnt
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]      FULL_LEVEL = DEPTH[AW:0];
  localparam logic [AW:0]      HI_LEVEL   = PAUSE_HI[AW:0];
  localparam logic [AW:0]      LO_LEVEL   = PAUSE_LO[AW:0];
  localparam logic [AW:0]      PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_MAX    = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       commit_ptr;
  logic [AW:0]       rd_ptr;

  wr_state_t         wr_state;
  wr_state_t         wr_state_nxt;
  logic [LEN_W-1:0]  len_cnt;
  logic [LEN_W-1:0]  cur_len;
  logic [LEN_W-1:0]  len_next;
  logic              overflow;
  logic              word_store;
  logic              frame_commit;
  logic              frame_drop;

  rd_state_t         rd_state;
  rd_state_t         rd_state_nxt;
  logic [LEN_W-1:0]  fetch_left;
  logic [LEN_W-1:0]  fetch_cnt;
  logic              load;
  logic              fetch;
  logic              last_accept;

  logic              len_full;
  logic              len_empty;
  logic [LEN_W-1:0]  len_head;

  assign level    = wr_ptr - rd_ptr;
  assign cur_len  = (wr_state == WR_IDLE) ? '0 : len_cnt;
  assign len_next = cur_len + LEN_ONE;
  assign overflow = (level == FULL_LEVEL) || (cur_len == LEN_MAX);

  sync_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (LEN_DEPTH)
  ) u_len_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (frame_commit),
    .din   (len_next),
    .pop   (last_accept),
    .dout  (len_head),
    .full  (len_full),
    .empty (len_empty),
    .count (frames)
  );

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  // Write FSM next state: a last word always closes the frame, a drop mid-frame discards the rest.
  always_comb begin
    wr_state_nxt = wr_state;
    if (wr_valid) begin
      if (wr_last)                    wr_state_nxt = WR_IDLE;
      else if (frame_drop)            wr_state_nxt = WR_DISCARD;
      else if (wr_state == WR_IDLE)   wr_state_nxt = WR_FILL;
    end
  end

  // Write FSM outputs: store, commit or drop the incoming word's frame.
  always_comb begin
    word_store   = 1'b0;
    frame_commit = 1'b0;
    frame_drop   = 1'b0;
    if (wr_valid) begin
      case (wr_state)
        WR_IDLE, WR_FILL: begin
          if (wr_state == WR_IDLE && len_full)      frame_drop = 1'b1;
          else if (overflow || (wr_last && wr_err)) frame_drop = 1'b1;
          else begin
            word_store   = 1'b1;
            frame_commit = wr_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Data memory write port.
  always_ff @(posedge clk) begin
    if (word_store) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Write pointers, frame length counter and drop counter; a drop rewinds to the last commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (frame_drop)      wr_ptr <= commit_ptr;
      else if (word_store) wr_ptr <= wr_ptr + PTR_ONE;
      if (frame_commit)    commit_ptr <= wr_ptr + PTR_ONE;
      if (word_store)      len_cnt <= len_next;
      if (frame_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Read FSM next state.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE:   if (!len_empty) rd_state_nxt = RD_STREAM;
      RD_STREAM: if (last_accept) rd_state_nxt = RD_NEXT;
      RD_NEXT:   rd_state_nxt = len_empty ? RD_IDLE : RD_STREAM;
      default:   rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM outputs: length load, memory fetch into the output register, queue pop.
  always_comb begin
    load        = 1'b0;
    fetch       = 1'b0;
    last_accept = rd_valid && rd_ready && rd_last;
    case (rd_state)
      RD_IDLE:   load = !len_empty;
      RD_STREAM: fetch = (fetch_left != '0) && (!rd_valid || rd_ready);
      RD_NEXT: begin
        load  = !len_empty;
        fetch = !len_empty;
      end
      default: ;
    endcase
  end

  assign fetch_cnt = load ? len_head : fetch_left;

  // Show-ahead output register fed by the registered memory read; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      fetch_left   <= '0;
      rd_len       <= '0;
      rd_len_valid <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_last      <= 1'b0;
    end else begin
      if (load) begin
        rd_len       <= len_head;
        rd_len_valid <= 1'b1;
      end else if (last_accept) begin
        rd_len_valid <= 1'b0;
      end
      if (fetch) begin
        rd_data    <= mem[rd_ptr[AW-1:0]];
        rd_valid   <= 1'b1;
        rd_last    <= (fetch_cnt == LEN_ONE);
        rd_ptr     <= rd_ptr + PTR_ONE;
        fetch_left <= fetch_cnt - LEN_ONE;
      end else begin
        if (load) fetch_left <= len_head;
        if (rd_ready) begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end
    end
  end

  // Hysteretic pause request, registered off the current level.
  always_ff @(posedge clk) begin
    if (!rst_n)                 pause_req <= 1'b0;
    else if (level >= HI_LEVEL) pause_req <= 1'b1;
    else if (level <= LO_LEVEL) pause_req <= 1'b0;
  end

endmodule

// File: tb/tb_frame_fifo.sv
// Scoreboard bench for frame_fifo: DEPTH=64, LEN_DEPTH=4, pause 48/16.
module tb_frame_fifo;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_err;
  logic        rd_len_valid;
  logic [15:0] rd_len;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        rd_ready;
  logic [6:0]  level;
  logic [2:0]  frames;
  logic        pause_req;
  logic [15:0] drop_cnt;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   len_q[$];
  bit   in_frame;
  int   n_checks;
  int   n_errors;
  int   exp_drops;

  frame_fifo #(
    .DATA_W    (8),
    .DEPTH     (64),
    .LEN_DEPTH (4),
    .LEN_W     (16),
    .PAUSE_HI  (48),
    .PAUSE_LO  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .wr_err       (wr_err),
    .rd_len_valid (rd_len_valid),
    .rd_len       (rd_len),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .rd_ready     (rd_ready),
    .level        (level),
    .frames       (frames),
    .pause_req    (pause_req),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic err, input logic keep);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      wr_last  = (i == n - 1);
      wr_err   = err && (i == n - 1);
      if (keep) sb.push_back('{data: base + 8'(i), last: (i == n - 1)});
      @(posedge clk); #1;
    end
    if (keep) len_q.push_back(n);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_err   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || rd_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check_val(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_len_valid"}, 32'(rd_len_valid), 32'd0);
    check_val({tag, "_rd_len"},    32'(rd_len),       32'd0);
    check_val({tag, "_rd_valid"},  32'(rd_valid),     32'd0);
    check_val({tag, "_rd_data"},   32'(rd_data),      32'd0);
    check_val({tag, "_rd_last"},   32'(rd_last),      32'd0);
    check_val({tag, "_level"},     32'(level),        32'd0);
    check_val({tag, "_frames"},    32'(frames),       32'd0);
    check_val({tag, "_pause"},     32'(pause_req),    32'd0);
    check_val({tag, "_drops"},     32'(drop_cnt),     32'd0);
  endtask

  // Words are taken at the next rising edge; compare them against the scoreboard here.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("rd_data", 32'(rd_data), 32'(e.data));
        check_val("rd_last", 32'(rd_last), 32'(e.last));
        if (!in_frame && len_q.size() != 0) begin
          check_val("rd_len",       32'(rd_len),       32'(len_q[0]));
          check_val("rd_len_valid", 32'(rd_len_valid), 32'd1);
          in_frame = 1'b1;
        end
        if (e.last) begin
          if (len_q.size() != 0) void'(len_q.pop_front());
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_drops = 0;
    in_frame  = 1'b0;
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    wr_err    = 1'b0;
    rd_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-word good frame: fills the buffer exactly, then reads back
    send_frame(64, 8'h00, 1'b0, 1'b1);
    check_val("t1_frames_one",      32'(frames),       32'd1);
    check_val("t1_len_valid_early", 32'(rd_len_valid), 32'd0);
    check_val("t1_level_full",      32'(level),        32'd64);
    @(posedge clk); #1;
    check_val("t1_len_valid",       32'(rd_len_valid), 32'd1);
    check_val("t1_rd_len",          32'(rd_len),       32'd64);
    check_val("t1_rd_valid_early",  32'(rd_valid),     32'd0);
    @(posedge clk); #1;
    check_val("t1_rd_valid",        32'(rd_valid),     32'd1);
    check_val("t1_first_data",      32'(rd_data),      32'd0);
    check_val("t1_level_prefetch",  32'(level),        32'd63);
    check_val("t1_pause_on",        32'(pause_req),    32'd1);
    rd_ready = 1'b1;
    wait_drain("t1_drain");
    rd_ready = 1'b0;
    @(posedge clk); #1;
    check_val("t1_frames_zero",     32'(frames),       32'd0);
    check_val("t1_level_zero",      32'(level),        32'd0);
    check_val("t1_len_valid_off",   32'(rd_len_valid), 32'd0);
    check_val("t1_pause_off",       32'(pause_req),    32'd0);

    // errored frame is discarded whole
    send_frame(10, 8'h80, 1'b1, 1'b0);
    exp_drops++;
    check_val("t2_level",  32'(level),    32'd0);
    check_val("t2_drops",  32'(drop_cnt), 32'(exp_drops));
    check_val("t2_frames", 32'(frames),   32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("t2_len_valid", 32'(rd_len_valid), 32'd0);
    check_val("t2_rd_valid",  32'(rd_valid),     32'd0);

    // second frame overflows the buffer while the first is stalled
    send_frame(40, 8'h10, 1'b0, 1'b1);
    send_frame(40, 8'hA0, 1'b0, 1'b0);
    exp_drops++;
    check_val("t3_drops",  32'(drop_cnt), 32'(exp_drops));
    check_val("t3_level",  32'(level),    32'd39);
    check_val("t3_frames", 32'(frames),   32'd1);
    rd_ready = 1'b1;
    wait_drain("t3_drain");
    rd_ready = 1'b0;
    @(posedge clk); #1;
    check_val("t3_level_zero",  32'(level),  32'd0);
    check_val("t3_frames_zero", 32'(frames), 32'd0);

    // length queue full: fifth back-to-back frame is dropped
    for (int i = 0; i < 4; i++) send_frame(2, 8'h20 + 8'(2 * i), 1'b0, 1'b1);
    send_frame(2, 8'hE0, 1'b0, 1'b0);
    exp_drops++;
    check_val("t4_frames", 32'(frames),   32'd4);
    check_val("t4_drops",  32'(drop_cnt), 32'(exp_drops));
    check_val("t4_level",  32'(level),    32'd7);
    rd_ready = 1'b1;
    wait_drain("t4_drain");
    rd_ready = 1'b0;
    @(posedge clk); #1;
    check_val("t4_frames_zero", 32'(frames), 32'd0);

    // pause hysteresis around 48 / 16
    check_val("t5_pause_start", 32'(pause_req), 32'd0);
    send_frame(48, 8'h40, 1'b0, 1'b1);
    check_val("t5_level_48",     32'(level),     32'd48);
    check_val("t5_pause_lag",    32'(pause_req), 32'd0);
    @(posedge clk); #1;
    check_val("t5_pause_rise",   32'(pause_req), 32'd1);
    @(posedge clk); #1;
    check_val("t5_level_47",     32'(level),     32'd47);
    rd_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rd_ready = 1'b0;
    check_val("t5_level_17",     32'(level),     32'd17);
    @(posedge clk); #1;
    check_val("t5_pause_at_17",  32'(pause_req), 32'd1);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    check_val("t5_level_16",     32'(level),     32'd16);
    check_val("t5_pause_lag_lo", 32'(pause_req), 32'd1);
    @(posedge clk); #1;
    check_val("t5_pause_fall",   32'(pause_req), 32'd0);
    rd_ready = 1'b1;
    wait_drain("t5_drain");
    rd_ready = 1'b0;

    // reset mid-frame while reading, then a clean frame
    send_frame(20, 8'h60, 1'b0, 1'b1);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hF0 + 8'(i);
      wr_last  = 1'b0;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    sb.delete();
    len_q.delete();
    in_frame  = 1'b0;
    exp_drops = 0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("t6_reset");
    rst_n = 1'b1;
    send_frame(12, 8'hC0, 1'b0, 1'b1);
    wait_drain("t6_drain");
    rd_ready = 1'b0;
    @(posedge clk); #1;
    check_val("t6_frames", 32'(frames),   32'd0);
    check_val("t6_level",  32'(level),    32'd0);
    check_val("t6_drops",  32'(drop_cnt), 32'(exp_drops));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
